// File: rtl/data_fifo_pkg.sv
// Shared definitions for the synchronous data FIFO: read-mode selectors and
// the width of the occupancy counter.
package data_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // The counter must represent 0..DEPTH inclusive, hence one bit more than a pointer.
    function automatic int cnt_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/data_fifo_sdp_ram.sv
// Simple dual-port memory with a registered read port, written so that
// synthesis maps it onto block RAM.
module data_fifo_sdp_ram #(
    parameter int WIDTH      = 18,
    parameter int DEPTH_LOG2 = 14
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // NOTE: neither the array nor its read register has a reset; adding one
    // would stop the memory mapping onto block RAM. Stale contents are never
    // presented because the FIFO pointers and counters are reset instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/data_fifo_sync.sv
// Single-clock FIFO with status flags, reject pulses and a selectable
// standard (1-cycle latency) or first-word-fall-through read port.
module data_fifo_sync
    import data_fifo_pkg::*;
#(
    parameter int WIDTH      = 18,
    parameter int DEPTH_LOG2 = 14,
    parameter int AFULL_VAL  = (1 << DEPTH_LOG2) - 4,
    parameter int AEMPTY_VAL = 4,
    parameter int FWFT       = FIFO_MODE_STD
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             clear,
    input  logic                             we,
    input  logic [WIDTH-1:0]                 data,
    input  logic                             re,
    output logic [WIDTH-1:0]                 q,
    output logic                             dvld,
    output logic                             full,
    output logic                             empty,
    output logic                             afull,
    output logic                             aempty,
    output logic [cnt_width(DEPTH_LOG2)-1:0] wrcnt,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int            CW         = cnt_width(DEPTH_LOG2);
    localparam logic [CW-1:0] DEPTH_CNT  = CW'(1 << DEPTH_LOG2);
    localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_VAL);
    localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_VAL);

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ram_rd_en;
    logic [WIDTH-1:0]      ram_rd_data;

    assign full   = (wrcnt == DEPTH_CNT);
    assign afull  = (wrcnt >= AFULL_CNT);
    assign aempty = (wrcnt <= AEMPTY_CNT);
    assign wr_acc = we && !full;
    assign rd_acc = re && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // in the block samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wrcnt     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wrcnt     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ram_rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                wrcnt <= wrcnt + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                wrcnt <= wrcnt - 1'b1;
            end
            overflow  <= we && full;
            underflow <= re && empty;
        end
    end

    data_fifo_sdp_ram #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .we      (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data),
        .re      (ram_rd_en),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        logic [1:0]       pf_cnt;
        logic             rd_pend;
        logic [WIDTH-1:0] head_q;
        logic [WIDTH-1:0] skid_q;
        logic [CW-1:0]    ram_cnt;
        logic [2:0]       pf_level;

        // Words still in RAM are those counted but neither prefetched nor in flight.
        assign ram_cnt   = wrcnt - CW'(pf_cnt) - CW'(rd_pend);
        // Prefetch occupancy after this edge; a new read only issues if its word will fit.
        assign pf_level  = {1'b0, pf_cnt} + {2'b00, rd_pend} - {2'b00, rd_acc};
        assign ram_rd_en = (ram_cnt != '0) && (pf_level <= 3'd1);
        assign empty     = (pf_cnt == 2'd0);
        assign dvld      = !empty;
        assign q         = head_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pf_cnt  <= 2'd0;
                rd_pend <= 1'b0;
                head_q  <= '0;
                skid_q  <= '0;
            end else if (clear) begin
                pf_cnt  <= 2'd0;
                rd_pend <= 1'b0;
                head_q  <= '0;
                skid_q  <= '0;
            end else begin
                rd_pend <= ram_rd_en;
                case (pf_cnt)
                    2'd0: begin
                        if (rd_pend) begin
                            head_q <= ram_rd_data;
                            pf_cnt <= 2'd1;
                        end
                    end
                    2'd1: begin
                        if (rd_pend) begin
                            if (rd_acc) begin
                                head_q <= ram_rd_data;
                            end else begin
                                skid_q <= ram_rd_data;
                                pf_cnt <= 2'd2;
                            end
                        end else if (rd_acc) begin
                            pf_cnt <= 2'd0;
                        end
                    end
                    default: begin
                        if (rd_acc) begin
                            head_q <= skid_q;
                            if (rd_pend) begin
                                skid_q <= ram_rd_data;
                            end else begin
                                pf_cnt <= 2'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end else begin : g_std
        logic             dvld_q;
        logic [WIDTH-1:0] q_last;

        assign empty     = (wrcnt == '0);
        assign ram_rd_en = rd_acc;
        assign dvld      = dvld_q;
        // The RAM read register has no reset, so Q falls back to a resettable copy.
        assign q         = dvld_q ? ram_rd_data : q_last;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dvld_q <= 1'b0;
                q_last <= '0;
            end else if (clear) begin
                dvld_q <= 1'b0;
                q_last <= '0;
            end else begin
                dvld_q <= ram_rd_en;
                if (dvld_q) begin
                    q_last <= ram_rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_fifo_sync.sv
// Self-checking bench for data_fifo_sync: one standard-mode and one FWFT
// instance, directed steps with a scoreboard of expected read words.
module tb_data_fifo_sync;

    logic        clk;
    logic        reset_n;
    logic        clear;

    logic        s_we, s_re, s_dvld, s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
    logic [17:0] s_data, s_q;
    logic [4:0]  s_wrcnt;

    logic        f_we, f_re, f_dvld, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
    logic [17:0] f_data, f_q;
    logic [4:0]  f_wrcnt;

    logic [17:0] sb_s[$];
    logic [17:0] sb_f[$];
    int          m_cnt;
    logic [17:0] m_q;

    int n_checks = 0;
    int n_fail   = 0;

    data_fifo_sync #(
        .WIDTH(18), .DEPTH_LOG2(4), .AFULL_VAL(14), .AEMPTY_VAL(2), .FWFT(0)
    ) dut_std (
        .clk(clk), .reset_n(reset_n), .clear(clear), .we(s_we), .data(s_data), .re(s_re),
        .q(s_q), .dvld(s_dvld), .full(s_full), .empty(s_empty), .afull(s_afull),
        .aempty(s_aempty), .wrcnt(s_wrcnt), .overflow(s_ovf), .underflow(s_unf)
    );

    data_fifo_sync #(
        .WIDTH(18), .DEPTH_LOG2(4), .AFULL_VAL(14), .AEMPTY_VAL(2), .FWFT(1)
    ) dut_fwft (
        .clk(clk), .reset_n(reset_n), .clear(clear), .we(f_we), .data(f_data), .re(f_re),
        .q(f_q), .dvld(f_dvld), .full(f_full), .empty(f_empty), .afull(f_afull),
        .aempty(f_aempty), .wrcnt(f_wrcnt), .overflow(f_ovf), .underflow(f_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        check("std_rst_q", s_q, 0);          check("fwft_rst_q", f_q, 0);
        check("std_rst_dvld", s_dvld, 0);    check("fwft_rst_dvld", f_dvld, 0);
        check("std_rst_full", s_full, 0);    check("fwft_rst_full", f_full, 0);
        check("std_rst_empty", s_empty, 1);  check("fwft_rst_empty", f_empty, 1);
        check("std_rst_afull", s_afull, 0);  check("fwft_rst_afull", f_afull, 0);
        check("std_rst_aempty", s_aempty, 1); check("fwft_rst_aempty", f_aempty, 1);
        check("std_rst_wrcnt", s_wrcnt, 0);  check("fwft_rst_wrcnt", f_wrcnt, 0);
        check("std_rst_ovf", s_ovf, 0);      check("fwft_rst_ovf", f_ovf, 0);
        check("std_rst_unf", s_unf, 0);      check("fwft_rst_unf", f_unf, 0);
    endtask

    // One standard-mode edge; the model predicts acceptance from its own count.
    task automatic cycle_std(input logic w, input logic [17:0] d, input logic r);
        logic wacc, racc;
        wacc = w && (m_cnt != 16);
        racc = r && (m_cnt != 0);
        s_we = w; s_data = d; s_re = r;
        @(posedge clk); #1;
        s_we = 1'b0; s_re = 1'b0;
        if (racc) m_q = sb_s.pop_front();
        if (wacc) sb_s.push_back(d);
        m_cnt = m_cnt + int'(wacc) - int'(racc);
        check("std_dvld", s_dvld, racc);
        check("std_q", s_q, m_q);
        check("std_wrcnt", s_wrcnt, m_cnt);
        check("std_full", s_full, m_cnt == 16);
        check("std_empty", s_empty, m_cnt == 0);
        check("std_afull", s_afull, m_cnt >= 14);
        check("std_aempty", s_aempty, m_cnt <= 2);
        check("std_ovf", s_ovf, w && !wacc);
        check("std_unf", s_unf, r && !racc);
    endtask

    // One FWFT edge; a pop consumes the word shown on Q before the edge.
    task automatic cycle_fwft(input logic w, input logic [17:0] d, input logic r);
        logic [31:0] exp;
        if (r && f_empty === 1'b0) begin
            exp = (sb_f.size() > 0) ? 32'(sb_f.pop_front()) : 32'hDEAD_BEEF;
            check("fwft_q", f_q, exp);
        end
        f_we = w; f_data = d; f_re = r;
        if (w) sb_f.push_back(d);
        @(posedge clk); #1;
        f_we = 1'b0; f_re = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0;
        s_we = 1'b0; s_re = 1'b0; s_data = '0;
        f_we = 1'b0; f_re = 1'b0; f_data = '0;
        m_cnt = 0; m_q = '0;
        repeat (3) @(posedge clk);
        #1 check_reset_state();
        reset_n = 1'b1;

        // FWFT: latency into an empty FIFO, then bubble-free draining
        cycle_fwft(1'b1, 18'h2A, 1'b0);
        check("fwft_wrcnt_first_wr", f_wrcnt, 1);
        cycle_fwft(1'b0, '0, 1'b0);
        cycle_fwft(1'b0, '0, 1'b0);
        check("fwft_empty_n2", f_empty, 0);
        check("fwft_q_n2", f_q, 18'h2A);
        check("fwft_dvld_n2", f_dvld, 1);
        cycle_fwft(1'b0, '0, 1'b1);
        check("fwft_empty_after_pop", f_empty, 1);
        check("fwft_wrcnt_after_pop", f_wrcnt, 0);
        for (int i = 0; i < 8; i++) cycle_fwft(1'b1, 18'(8'h30 + i), 1'b0);
        repeat (3) cycle_fwft(1'b0, '0, 1'b0);
        check("fwft_wrcnt_8", f_wrcnt, 8);
        for (int i = 0; i < 8; i++) begin
            check("fwft_nobubble", f_dvld, 1);
            cycle_fwft(1'b0, '0, 1'b1);
        end
        check("fwft_drained_empty", f_empty, 1);
        check("fwft_drained_wrcnt", f_wrcnt, 0);
        check("fwft_sb_drained", sb_f.size(), 0);
        cycle_fwft(1'b0, '0, 1'b1);
        check("fwft_unf", f_unf, 1);

        // Standard: fill, overflow, drain, underflow
        for (int i = 0; i < 16; i++) cycle_std(1'b1, 18'(i), 1'b0);
        cycle_std(1'b1, 18'h3FFFF, 1'b0);
        cycle_std(1'b0, '0, 1'b0);
        for (int i = 0; i < 16; i++) cycle_std(1'b0, '0, 1'b1);
        cycle_std(1'b0, '0, 1'b1);
        cycle_std(1'b0, '0, 1'b0);

        // Simultaneous requests at full and mid-level
        for (int i = 0; i < 16; i++) cycle_std(1'b1, 18'(12'h100 + i), 1'b0);
        cycle_std(1'b1, 18'h2AA, 1'b1);
        for (int i = 0; i < 7; i++) cycle_std(1'b0, '0, 1'b1);
        check("std_level_8", s_wrcnt, 8);
        cycle_std(1'b1, 18'h155, 1'b1);
        for (int i = 0; i < 8; i++) cycle_std(1'b0, '0, 1'b1);
        cycle_std(1'b0, '0, 1'b0);

        // Streaming 40 words with occupancy held roughly between 3 and 10
        begin
            int w_idx;
            logic w, r;
            w_idx = 0;
            for (int c = 0; c < 2000 && w_idx < 40; c++) begin
                w = (m_cnt < 10) && (m_cnt < 3 || $urandom_range(0, 1) == 1);
                r = (m_cnt > 3) && (m_cnt >= 10 || $urandom_range(0, 1) == 1);
                cycle_std(w, 18'(12'h200 + w_idx), r);
                if (w) w_idx++;
            end
            check("std_stream_written", w_idx, 40);
            for (int c = 0; c < 16 && m_cnt > 0; c++) cycle_std(1'b0, '0, 1'b1);
            check("std_stream_sb_empty", sb_s.size(), 0);
        end

        // Reset pulse in the middle of traffic
        for (int i = 0; i < 3; i++) cycle_fwft(1'b1, 18'(12'h3A0 + i), 1'b0);
        for (int i = 0; i < 5; i++) cycle_std(1'b1, 18'(12'h3C0 + i), 1'b0);
        #2 reset_n = 1'b0;
        #1 check_reset_state();
        sb_s.delete(); sb_f.delete(); m_cnt = 0; m_q = '0;
        @(posedge clk); #1 reset_n = 1'b1;
        cycle_std(1'b1, 18'h11, 1'b0);
        cycle_std(1'b1, 18'h22, 1'b0);
        cycle_std(1'b0, '0, 1'b1);
        cycle_std(1'b0, '0, 1'b1);
        cycle_std(1'b0, '0, 1'b0);
        cycle_fwft(1'b1, 18'h33, 1'b0);
        cycle_fwft(1'b0, '0, 1'b0);
        cycle_fwft(1'b0, '0, 1'b0);
        check("fwft_post_rst_q", f_q, 18'h33);
        cycle_fwft(1'b0, '0, 1'b1);
        check("fwft_post_rst_empty", f_empty, 1);

        // Synchronous clear overrides concurrent requests
        for (int i = 0; i < 3; i++) cycle_std(1'b1, 18'(8'h44 + i), 1'b0);
        clear = 1'b1; s_we = 1'b1; s_data = 18'h55; s_re = 1'b1; f_re = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; s_we = 1'b0; s_re = 1'b0; f_re = 1'b0;
        sb_s.delete(); m_cnt = 0; m_q = '0;
        check_reset_state();
        cycle_std(1'b1, 18'h66, 1'b0);
        cycle_std(1'b0, '0, 1'b1);
        cycle_std(1'b0, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
